// File: rtl/mc_mainfsm.sv
// mc_mainfsm: Moore control FSM for the multicycle MIPS core.
// Steps each instruction through fetch/decode/execute/writeback states
// and drives all datapath enables, mux selects and the ALU op code.
module mc_mainfsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic [3:0] state,
   output logic       pcen,
   output logic       pcwrite,
   output logic       branch,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic       memtoreg,
   output logic       regdst,
   output logic       zext,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      ORIEX   = 4'd12,
      ORIWB   = 4'd13
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t r_state;
   state_t w_next;

   // State register; reset returns to FETCH without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   // Next-state decode and Moore outputs; everything defaults to 0 / FETCH.
   always_comb begin
      w_next   = FETCH;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      zext     = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      case (r_state)
         FETCH: begin
            w_next  = DECODE;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: w_next = MEMADR;
               OP_RTYPE:     w_next = RTYPEEX;
               OP_BEQ:       w_next = BEQEX;
               OP_ADDI:      w_next = ADDIEX;
               OP_ORI:       w_next = ORIEX;
               OP_J:         w_next = JEX;
               default:      w_next = FETCH;   // unknown opcode runs as a nop
            endcase
         end
         MEMADR: begin
            w_next  = (op == OP_LW) ? MEMRD : MEMWR;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            w_next = MEMWB;
            iord   = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            w_next  = RTYPEWB;
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            w_next  = ADDIWB;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB: regwrite = 1'b1;
         ORIEX: begin
            w_next  = ORIWB;
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
            zext    = 1'b1;
         end
         ORIWB: regwrite = 1'b1;
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: w_next = FETCH;   // illegal codes recover to FETCH
      endcase
   end

   // The only input-dependent output: branch only asserts in BEQEX.
   assign pcen  = pcwrite | (branch & zero);
   assign state = r_state;

endmodule
